mem_2r1w_be: RTL and testbench
==============================

MEM_2R1W_BE -- requirements
Module: mem_2r1w_be

Interface
REQ-001 SHALL have parameter WIDTH, default 32: word width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64: number of words, ≥2, need not be a power of two.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency of 0 (combinational) or 1 (registered).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1: whether a zero-fill sequence runs after reset.
REQ-005 SHALL have parameter MEMDATA, default "": hex init file, loaded at time zero if non-empty.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports rd_addr0 and rd_addr1, input, AW = $clog2(DEPTH)+2 bits: byte addresses.
REQ-009 SHALL have ports rd_en0 and rd_en1, input, 1 bit each: read requests.
REQ-010 SHALL have ports rd_dout0 and rd_dout1, output, WIDTH bits each: read data.
REQ-011 SHALL have ports rd_valid0 and rd_valid1, output, 1 bit each: read data qualifiers.
REQ-012 SHALL have port wr_addr0, input, AW bits: byte address.
REQ-013 SHALL have port wr_din0, input, WIDTH bits: write data.
REQ-014 SHALL have port wr_be0, input, WIDTH/8 bits: byte enables.
REQ-015 SHALL have port we0, input, 1 bit: write request.
REQ-016 SHALL have port busy, output, 1 bit: zero-fill in progress.
REQ-017 SHALL have port addr_err, output, 1 bit: out-of-range access flagged this cycle.

Function
REQ-018 SHALL form each word index as addr[AW-1:2]; addr[1:0] SHALL be ignored.
REQ-019 SHALL, when we0=1 and index<DEPTH and busy=0, update only the bytes whose wr_be0 bit is set; other bytes hold.
REQ-020 SHALL, with RD_LATENCY=0, drive rd_doutN = mem[index] combinationally and rd_validN = rd_enN & ~busy.
REQ-021 SHALL, with RD_LATENCY=1, register rd_doutN and rd_validN one cycle after rd_enN; rd_doutN holds its value when rd_enN=0.
REQ-022 SHALL resolve a same-cycle write and read to one index as write-first: the read returns the byte-merged new word (bypass). With RD_LATENCY=0 this is a combinational merge.
REQ-023 SHALL return 0 with rd_validN=1 for an out-of-range read, and SHALL ignore an out-of-range write.
REQ-024 SHALL set addr_err combinationally when any active request (rd_en0, rd_en1 or we0) has index≥DEPTH.
REQ-025 SHALL implement the FSM IDLE→CLEAR on reset release when CLEAR_ON_RESET=1, and CLEAR→IDLE after writing index DEPTH-1.
REQ-026 SHALL, in CLEAR, zero one word per cycle with a counter running 0..DEPTH-1 and hold busy=1.
REQ-027 SHALL, while busy=1, ignore we0 and force rd_validN=0 and rd_doutN=0.
REQ-028 SHALL accept both read ports and the write port every cycle with no back-pressure.

Reset
REQ-029 SHALL, while rst=1, force rd_dout0, rd_dout1, rd_valid0 and rd_valid1 to 0, reset the counter to 0, and hold the FSM in CLEAR if CLEAR_ON_RESET=1 (else IDLE).
REQ-030 SHALL set busy=CLEAR_ON_RESET while rst=1.
REQ-031 SHALL NOT reset memory contents directly; zeroing occurs only through the CLEAR sequence.
REQ-032 SHALL restart the CLEAR sequence at index 0 when rst is asserted mid-sequence.

Structure
REQ-033 SHALL place the address-to-index function and byte-merge function in shared package mem_pkg, with FSM state encodings.
REQ-034 SHALL use one sub-module, mem_rd_port, instantiated twice, containing bypass merge, range check and the optional output register.

Verification
REQ-035 SHALL verify reset clear: DEPTH=8, CLEAR_ON_RESET=1, release rst → busy=1 for exactly 8 cycles, then reading each index returns 0.
REQ-036 SHALL verify byte enables: write 0xAABBCCDD with be=4'b1111 at addr 0x04, then 0x11223344 with be=4'b0101 → read gives 0xAA22CC44.
REQ-037 SHALL verify bypass: same-cycle we0, rd_en0 at addr 0x08 with din 0xDEADBEEF, be=4'b1111 → rd_dout0=0xDEADBEEF (next cycle if RD_LATENCY=1).
REQ-038 SHALL verify dual read: ports 0 and 1 read indices 2 and 5 in the same cycle → both values correct, both valid.
REQ-039 SHALL verify range: DEPTH=6, write to addr 0x18 → addr_err=1 and no memory change; read of 0x18 → dout 0, valid 1.
REQ-040 SHALL verify mid-clear reset: assert rst at counter 3 → counter restarts at 0 and busy lasts a further 8 cycles after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared helpers for the byte-enabled 2R1W memory: address-to-index, byte merge, FSM states.
package mem_pkg;
  localparam int MAX_W = 256;
  localparam int MAX_B = MAX_W / 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  // Byte address to word index; the two low bits select a byte and are dropped.
  function automatic logic [31:0] addr2idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Callers widen to MAX_W and truncate the result back to their own WIDTH.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int b = 0; b < MAX_B; b++)
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    return m;
  endfunction
endpackage

// File: rtl/mem_rd_port.sv
// One read port: range check, write-first bypass merge and optional output register.
module mem_rd_port
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 1,
  localparam int AW = $clog2(DEPTH) + 2,
  localparam int IW = AW - 2,
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_busy,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_din,
  input  logic [NB-1:0]    i_wr_be,
  output logic [IW-1:0]    o_idx,
  output logic             o_err,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid
);
  logic [31:0]      w_idx;
  logic             w_inr;
  logic             w_hit;
  logic [WIDTH-1:0] w_data;

  assign w_idx = addr2idx(32'(i_addr));
  assign w_inr = (w_idx < 32'(DEPTH));
  assign o_idx = IW'(w_idx);
  assign o_err = i_en & ~w_inr;
  // i_wr_en is already range-qualified, so a hit implies an in-range index.
  assign w_hit = i_wr_en & (i_wr_idx == o_idx);

  always_comb begin
    w_data = '0;
    if (w_inr)
      w_data = w_hit ? WIDTH'(byte_merge(MAX_W'(i_word), MAX_W'(i_wr_din), MAX_B'(i_wr_be)))
                     : i_word;
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb
      assign o_valid = i_en & ~i_busy & ~rst;
      assign o_dout  = (i_busy | rst) ? '0 : w_data;
    end else begin : g_reg
      logic             r_valid;
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_dout  <= '0;
        end else begin
          r_valid <= i_en & ~i_busy;
          if (i_busy)    r_dout <= '0;
          else if (i_en) r_dout <= w_data;
        end
      end
      assign o_valid = r_valid & ~i_busy & ~rst;
      assign o_dout  = (i_busy | rst) ? '0 : r_dout;
    end
  endgenerate
endmodule

// File: rtl/mem_2r1w_be.sv
// Two-read one-write byte-enabled memory with optional zero-fill after reset.
module mem_2r1w_be
  import mem_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 64,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter     MEMDATA        = "",
  localparam int AW = $clog2(DEPTH) + 2,
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  input  logic             rd_en0,
  input  logic             rd_en1,
  output logic [WIDTH-1:0] rd_dout0,
  output logic [WIDTH-1:0] rd_dout1,
  output logic             rd_valid0,
  output logic             rd_valid1,
  input  logic [AW-1:0]    wr_addr0,
  input  logic [WIDTH-1:0] wr_din0,
  input  logic [NB-1:0]    wr_be0,
  input  logic             we0,
  output logic             busy,
  output logic             addr_err
);
  localparam int IW  = AW - 2;
  localparam int NRP = 2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_cnt, w_cnt_nxt;

  logic [31:0]      w_wr_idx32;
  logic [IW-1:0]    w_wr_idx;
  logic             w_wr_inr, w_wr_en;
  logic [WIDTH-1:0] w_wr_word;

  logic [NRP-1:0][AW-1:0]    w_raddr;
  logic [NRP-1:0]            w_ren, w_rvld, w_rerr;
  logic [NRP-1:0][IW-1:0]    w_ridx;
  logic [NRP-1:0][WIDTH-1:0] w_rdout;

  assign busy = rst ? CLEAR_ON_RESET : (r_state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == IW'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign w_wr_idx32 = addr2idx(32'(wr_addr0));
  assign w_wr_inr   = (w_wr_idx32 < 32'(DEPTH));
  assign w_wr_idx   = IW'(w_wr_idx32);
  assign w_wr_en    = we0 & w_wr_inr & ~busy;
  assign w_wr_word  = WIDTH'(byte_merge(MAX_W'(r_mem[w_wr_idx]), MAX_W'(wr_din0), MAX_B'(wr_be0)));

  // Zero-fill only runs out of reset so memory is never cleared by rst itself.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR && !rst) r_mem[r_cnt]    <= '0;
    else if (w_wr_en)                r_mem[w_wr_idx] <= w_wr_word;
  end

  assign w_raddr = {rd_addr1, rd_addr0};
  assign w_ren   = {rd_en1, rd_en0};

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    mem_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)) u_rd (
      .clk      (clk),
      .rst      (rst),
      .i_busy   (busy),
      .i_en     (w_ren[p]),
      .i_addr   (w_raddr[p]),
      .i_word   (r_mem[w_ridx[p]]),
      .i_wr_en  (w_wr_en),
      .i_wr_idx (w_wr_idx),
      .i_wr_din (wr_din0),
      .i_wr_be  (wr_be0),
      .o_idx    (w_ridx[p]),
      .o_err    (w_rerr[p]),
      .o_dout   (w_rdout[p]),
      .o_valid  (w_rvld[p])
    );
  end

  assign {rd_dout1, rd_dout0}   = w_rdout;
  assign {rd_valid1, rd_valid0} = w_rvld;
  assign addr_err = |w_rerr | (we0 & ~w_wr_inr);
endmodule

// File: tb/tb_mem_2r1w_be.sv
// Scoreboard bench: a registered 8-word instance and a combinational 6-word instance.
module tb_mem_2r1w_be;
  localparam int W   = 32;
  localparam int DA  = 8;
  localparam int AWA = $clog2(DA) + 2;
  localparam int DB  = 6;
  localparam int AWB = $clog2(DB) + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, re0, re1, we, v0, v1, busy_a, err_a;
  logic [AWA-1:0] ra0, ra1, wa;
  logic [W-1:0]   wd, do0, do1;
  logic [3:0]     wbe;

  logic           rst_b, reb0, reb1, web, vb0, vb1, busy_b, err_b;
  logic [AWB-1:0] rb0, rb1, wab;
  logic [W-1:0]   wdb, dob0, dob1;
  logic [3:0]     wbeb;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] qa0[$], qa1[$], qb0[$], qb1[$];

  mem_2r1w_be #(.WIDTH(W), .DEPTH(DA), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .rd_addr0(ra0), .rd_addr1(ra1), .rd_en0(re0), .rd_en1(re1),
    .rd_dout0(do0), .rd_dout1(do1), .rd_valid0(v0), .rd_valid1(v1),
    .wr_addr0(wa), .wr_din0(wd), .wr_be0(wbe), .we0(we), .busy(busy_a), .addr_err(err_a));

  mem_2r1w_be #(.WIDTH(W), .DEPTH(DB), .RD_LATENCY(0), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .rd_addr0(rb0), .rd_addr1(rb1), .rd_en0(reb0), .rd_en1(reb1),
    .rd_dout0(dob0), .rd_dout1(dob1), .rd_valid0(vb0), .rd_valid1(vb1),
    .wr_addr0(wab), .wr_din0(wdb), .wr_be0(wbeb), .we0(web), .busy(busy_b), .addr_err(err_b));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [W-1:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: valid with no pending read, got %h want none", nm, act);
  endtask

  // Monitor: pops one expected word per presented valid.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      if (qa0.size() == 0) unexpected("a_rd0", do0);
      else chk("a_rd0", do0, qa0.pop_front());
    end
    if (v1 === 1'b1) begin
      if (qa1.size() == 0) unexpected("a_rd1", do1);
      else chk("a_rd1", do1, qa1.pop_front());
    end
    if (vb0 === 1'b1) begin
      if (qb0.size() == 0) unexpected("b_rd0", dob0);
      else chk("b_rd0", dob0, qb0.pop_front());
    end
    if (vb1 === 1'b1) begin
      if (qb1.size() == 0) unexpected("b_rd1", dob1);
      else chk("b_rd1", dob1, qb1.pop_front());
    end
  end

  // Counts busy cycles of instance A after release; a read is held pending throughout.
  task automatic count_busy(input string nm, input int exp);
    int n;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy_a === 1'b1) begin
        n++;
        chk("a_busy_nvalid", W'(v0), 0);
      end else begin
        re0 = 1'b0;
        break;
      end
    end
    chk(nm, W'(n), W'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; re0 = 1'b0; re1 = 1'b0; we = 1'b0; ra0 = '0; ra1 = '0; wa = '0; wd = '0; wbe = '0;
    rst_b = 1'b1; reb0 = 1'b0; reb1 = 1'b0; web = 1'b0; rb0 = '0; rb1 = '0; wab = '0; wdb = '0; wbeb = '0;

    repeat (3) @(posedge clk);
    re0 = 1'b1; ra0 = AWA'(8);
    @(negedge clk);
    chk("a_busy_rst", W'(busy_a), 1);
    chk("a_v0_rst", W'(v0), 0);
    chk("a_dout0_rst", do0, 0);
    chk("b_busy_rst", W'(busy_b), 0);

    @(posedge clk); #1 rst_a = 1'b0;
    count_busy("a_clear_len", DA);

    for (int i = 0; i < DA; i++) begin
      @(posedge clk); #1;
      re0 = 1'b1; ra0 = AWA'(i * 4);
      re1 = 1'b1; ra1 = AWA'((DA - 1 - i) * 4 + 3);
      qa0.push_back('0); qa1.push_back('0);
    end
    @(posedge clk); #1 re0 = 1'b0; re1 = 1'b0;

    // Byte enables
    we = 1'b1; wa = AWA'(4); wd = 32'hAABBCCDD; wbe = 4'b1111;
    @(posedge clk); #1 wd = 32'h11223344; wbe = 4'b0101;
    @(posedge clk); #1 we = 1'b0; re0 = 1'b1; ra0 = AWA'(4); qa0.push_back(32'hAA22CC44);

    // Full-word bypass
    @(posedge clk); #1 ra0 = AWA'(8); we = 1'b1; wa = AWA'(8); wd = 32'hDEADBEEF; wbe = 4'b1111;
    qa0.push_back(32'hDEADBEEF);
    // Partial bypass on port 1
    @(posedge clk); #1 re0 = 1'b0; wa = AWA'(12); wd = 32'h01020304; wbe = 4'b1111;
    @(posedge clk); #1 wd = 32'hFFFFAAAA; wbe = 4'b0011; re1 = 1'b1; ra1 = AWA'(12);
    qa1.push_back(32'h0102AAAA);

    // Dual read, with nonzero low address bits on port 1
    @(posedge clk); #1 re1 = 1'b0; wa = AWA'(20); wd = 32'h55AA55AA; wbe = 4'b1111;
    @(posedge clk); #1 we = 1'b0; re0 = 1'b1; ra0 = AWA'(9); re1 = 1'b1; ra1 = AWA'(23);
    qa0.push_back(32'hDEADBEEF); qa1.push_back(32'h55AA55AA);
    #1 chk("a_err_inrange", W'(err_a), 0);
    @(posedge clk); #1 re0 = 1'b0; re1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("a_hold_dout0", do0, 32'hDEADBEEF);
    chk("a_hold_valid0", W'(v0), 0);

    // Reset forces outputs, then reset again at counter 3
    @(posedge clk); #1 rst_a = 1'b1;
    @(negedge clk);
    chk("a_rst_dout0", do0, 0);
    chk("a_rst_busy", W'(busy_a), 1);
    @(posedge clk); #1 rst_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; re0 = 1'b1; ra0 = AWA'(8);
    @(posedge clk); #1 rst_a = 1'b0;
    count_busy("a_restart_len", DA);

    @(posedge clk); #1 re0 = 1'b1; ra0 = AWA'(8); re1 = 1'b1; ra1 = AWA'(20);
    qa0.push_back('0); qa1.push_back('0);
    @(posedge clk); #1 ra0 = AWA'(12); re1 = 1'b0; qa0.push_back('0);
    @(posedge clk); #1 re0 = 1'b0;

    // Instance B: combinational reads, DEPTH=6 range handling
    @(posedge clk); #1 rst_b = 1'b0;
    for (int i = 0; i < DB; i++) begin
      @(posedge clk); #1;
      web = 1'b1; wab = AWB'(i * 4); wdb = W'(32'h10000000 + i); wbeb = 4'b1111;
    end
    @(posedge clk); #1 wab = AWB'(24); wdb = 32'hFFFFFFFF;
    #1 chk("b_err_wr", W'(err_b), 1);
    @(posedge clk); #1 web = 1'b0;
    for (int i = 0; i < DB; i += 2) begin
      @(posedge clk); #1;
      reb0 = 1'b1; rb0 = AWB'(i * 4);
      reb1 = 1'b1; rb1 = AWB'(i * 4 + 5);
      qb0.push_back(W'(32'h10000000 + i)); qb1.push_back(W'(32'h10000001 + i));
      #1 chk("b_err_inrange", W'(err_b), 0);
    end
    @(posedge clk); #1 rb0 = AWB'(24); rb1 = AWB'(27);
    qb0.push_back('0); qb1.push_back('0);
    #1 chk("b_err_rd", W'(err_b), 1);
    @(posedge clk); #1 reb1 = 1'b0; rb0 = AWB'(4);
    web = 1'b1; wab = AWB'(4); wdb = 32'hAB000000; wbeb = 4'b1000;
    qb0.push_back(32'hAB000001);
    @(posedge clk); #1 web = 1'b0; qb0.push_back(32'hAB000001);
    @(posedge clk); #1 reb0 = 1'b0;

    repeat (3) @(posedge clk);
    chk("a_queue_drained", W'(qa0.size() + qa1.size()), 0);
    chk("b_queue_drained", W'(qb0.size() + qb1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
